// File: rtl/iobuf_arb_if.sv
// Requester/IOBUF bundle for iobuf_arb: three single-beat requesters plus the T/I/O pins of one IOBUF.
// Handshake: a requester holds req[k] (with wr[k] and its wdata slice stable) until it sees done[k]; done[k] is high for exactly one cycle (the XFER cycle) and the requester drops or renews req[k] at the edge that ends it.
interface iobuf_arb_if #(parameter int DW = 8);
  logic [2:0]      req;
  logic [2:0]      wr;
  logic [3*DW-1:0] wdata;
  logic [2:0]      gnt;
  logic [2:0]      done;
  logic [DW-1:0]   rdata;
  logic            rdata_vld;
  logic            busy;
  logic            buf_t;
  logic [DW-1:0]   buf_i;
  logic [DW-1:0]   buf_o;

  modport slave (
    input  req, wr, wdata, buf_o,
    output gnt, done, rdata, rdata_vld, busy, buf_t, buf_i
  );

  modport master (
    output req, wr, wdata, buf_o,
    input  gnt, done, rdata, rdata_vld, busy, buf_t, buf_i
  );
endinterface

// File: rtl/iobuf_arb.sv
// Round-robin arbiter and direction sequencer for one shared IOBUF, with turnaround cycles between owners.
// Optional bus parking while idle is enabled by defining IOBUF_ARB_PARK_EN.
module iobuf_arb #(
  parameter int DW = 8,
  parameter int TA = 2
) (
  input  logic        clk,
  input  logic        rst,
  iobuf_arb_if.slave  bus,
  output logic [1:0]  o_dbg_state
);

`ifdef IOBUF_ARB_PARK_EN
  localparam bit PARK = 1'b1;
`else
  localparam bit PARK = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PRE  = 2'd1,
    S_XFER = 2'd2,
    S_TURN = 2'd3
  } state_t;

  state_t          r_state, w_next;
  logic [1:0]      r_ptr, r_owner;
  logic            r_wr;
  logic [DW-1:0]   r_data;
  logic [3:0]      r_cnt;
  logic [2:0]      r_gnt;
  logic            r_buf_t;
  logic [DW-1:0]   r_buf_i;
  logic [DW-1:0]   r_rdata;
  logic            r_rdata_vld;

  logic [2:0]      w_rot;
  logic [2:0]      w_sum;
  logic [1:0]      w_sel;
  logic            w_sel_wr;
  logic [DW-1:0]   w_sel_data;
  logic            w_arb;
  logic [1:0]      w_owner;
  logic            w_wr;
  logic [DW-1:0]   w_data;
  logic [2:0]      w_gnt_n;
  logic            w_buf_t_n;
  logic [DW-1:0]   w_buf_i_n;

  // Rotate req so bit 0 is the current highest-priority requester, pick the first set bit.
  always_comb begin
    case (r_ptr)
      2'd1:    w_rot = {bus.req[0], bus.req[2:1]};
      2'd2:    w_rot = {bus.req[1:0], bus.req[2]};
      default: w_rot = bus.req;
    endcase
    if (w_rot[0])      w_sum = {1'b0, r_ptr};
    else if (w_rot[1]) w_sum = {1'b0, r_ptr} + 3'd1;
    else               w_sum = {1'b0, r_ptr} + 3'd2;
    w_sel = (w_sum >= 3'd3) ? 2'(w_sum - 3'd3) : w_sum[1:0];
  end

  always_comb begin
    case (w_sel)
      2'd1:    begin w_sel_wr = bus.wr[1]; w_sel_data = bus.wdata[DW +: DW];   end
      2'd2:    begin w_sel_wr = bus.wr[2]; w_sel_data = bus.wdata[2*DW +: DW]; end
      default: begin w_sel_wr = bus.wr[0]; w_sel_data = bus.wdata[0 +: DW];    end
    endcase
  end

  assign w_arb   = (r_state == S_IDLE) && (|bus.req);
  assign w_owner = (r_state == S_IDLE) ? w_sel      : r_owner;
  assign w_wr    = (r_state == S_IDLE) ? w_sel_wr   : r_wr;
  assign w_data  = (r_state == S_IDLE) ? w_sel_data : r_data;

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (|bus.req) w_next = (PARK && !w_sel_wr && TA > 0) ? S_PRE : S_XFER;
      S_PRE:  if (r_cnt == 4'd0) w_next = S_XFER;
      S_XFER: begin
        if (r_wr) w_next = (!PARK && TA > 0) ? S_TURN : S_IDLE;
        else      w_next = (PARK && TA > 0)  ? S_TURN : S_IDLE;
      end
      S_TURN: if (r_cnt == 4'd0) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Output logic: values the registered outputs take in the next cycle.
  always_comb begin
    w_gnt_n   = 3'b000;
    w_buf_t_n = 1'b1;
    w_buf_i_n = r_buf_i;
    if (w_next == S_XFER) w_gnt_n = 3'(3'b001 << w_owner);
    if (w_next == S_XFER && w_wr) begin
      w_buf_t_n = 1'b0;
      w_buf_i_n = w_data;
    end else if (PARK && w_next == S_IDLE) begin
      w_buf_t_n = 1'b0;
      w_buf_i_n = '0;
    end
  end

  // State register and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ptr       <= 2'd0;
      r_owner     <= 2'd0;
      r_wr        <= 1'b0;
      r_data      <= '0;
      r_cnt       <= 4'd0;
      r_gnt       <= 3'b000;
      r_buf_t     <= 1'b1;
      r_buf_i     <= '0;
      r_rdata     <= '0;
      r_rdata_vld <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_arb) begin
        r_owner <= w_sel;
        r_wr    <= w_sel_wr;
        r_data  <= w_sel_data;
        r_ptr   <= (w_sel == 2'd2) ? 2'd0 : w_sel + 2'd1;
      end
      if (w_next != r_state && (w_next == S_PRE || w_next == S_TURN))
        r_cnt <= 4'(TA - 1);
      else if (r_cnt != 4'd0)
        r_cnt <= r_cnt - 4'd1;
      r_gnt   <= w_gnt_n;
      r_buf_t <= w_buf_t_n;
      r_buf_i <= w_buf_i_n;
      r_rdata_vld <= (r_state == S_XFER) && !r_wr;
      if (r_state == S_XFER && !r_wr) r_rdata <= bus.buf_o;
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.done      = r_gnt;
  assign bus.rdata     = r_rdata;
  assign bus.rdata_vld = r_rdata_vld;
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.buf_t     = r_buf_t;
  assign bus.buf_i     = r_buf_i;
  assign o_dbg_state   = r_state;

endmodule
